// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register that feeds the EX-stage ALU. It registers the
// decoded ID fields and forwards EX/MEM and MEM/WB results onto the
// registered operands. It picks the immediate for operand B, and it detects
// load-use hazards.
//
// Valid semantics: the ID stage presents one instruction per cycle, qualified
// by id_valid. There is no ready signal going back into ID. Instead, lu_stall
// tells upstream to hold PC and IF/ID, and this stage loads a bubble in the
// same cycle. EX holds a real instruction exactly when ex_valid is 1.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   id_*                   decoded instruction fields from ID
//   flush                  squash the ID instruction (branch/jump redirect)
//   exmem_*, memwb_*       forwarding / write-through sources
//   lu_stall               combinational load-use stall request
//   ex_*                   registered EX fields and forwarded ALU operands
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [W-1:0]  id_pc,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_wreg,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_checkover,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_wreg,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_wreg,
  input  logic [W-1:0]  memwb_data,
  output logic          lu_stall,
  output logic          ex_valid,
  output logic [W-1:0]  ex_pc,
  output logic [4:0]    ex_aluop,
  output logic [4:0]    ex_shamt,
  output logic          ex_checkover,
  output logic [W-1:0]  ex_dataa,
  output logic [W-1:0]  ex_datab,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg
);

  // Registered EX state
  logic          valid_q;
  logic [W-1:0]  pc_q;
  logic [4:0]    aluop_q;
  logic [4:0]    shamt_q;
  logic          checkover_q;
  logic          alusrc_q;
  logic [W-1:0]  rs_data_q;
  logic [W-1:0]  rt_data_q;
  logic [W-1:0]  imm_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] wreg_q;
  logic          regwrite_q;
  logic          memread_q;
  logic          memwrite_q;
  logic          memtoreg_q;

  logic [W-1:0]  rs_capture;
  logic [W-1:0]  rt_capture;
  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;
  logic          bubble;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time, so ID must wait one cycle. Reset masks the request so
  // that stale EX state cannot freeze the front end while reset is applied.
  assign lu_stall = !rst && id_valid && valid_q && memread_q &&
                    (wreg_q != '0) && ((wreg_q == id_rs) || (wreg_q == id_rt));

  assign bubble = rst || flush || lu_stall;

  // The register file is written in the same cycle it is read. Capture the
  // MEM/WB value directly so that the write is not lost between stages.
  assign rs_capture = (memwb_regwrite && (memwb_wreg == id_rs) && (id_rs != '0))
                      ? memwb_data : id_rs_data;
  assign rt_capture = (memwb_regwrite && (memwb_wreg == id_rt) && (id_rt != '0))
                      ? memwb_data : id_rt_data;

  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= '0;
      shamt_q     <= '0;
      checkover_q <= 1'b0;
      alusrc_q    <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      aluop_q     <= id_aluop;
      shamt_q     <= id_shamt;
      checkover_q <= id_checkover && id_valid;
      alusrc_q    <= id_alusrc;
      rs_data_q   <= rs_capture;
      rt_data_q   <= rt_capture;
      imm_q       <= id_imm;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      wreg_q      <= id_wreg;
      // A non-instruction in ID must never produce side effects downstream.
      regwrite_q  <= id_regwrite && id_valid;
      memread_q   <= id_memread && id_valid;
      memwrite_q  <= id_memwrite && id_valid;
      memtoreg_q  <= id_memtoreg && id_valid;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB. Register 0 is
  // hard-wired to zero and is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (rs_q == '0) begin
      fwd_rs = '0;
    end else if (exmem_regwrite && (exmem_wreg == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwrite && (memwb_wreg == rs_q)) begin
      fwd_rs = memwb_data;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (rt_q == '0) begin
      fwd_rt = '0;
    end else if (exmem_regwrite && (exmem_wreg == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwrite && (memwb_wreg == rt_q)) begin
      fwd_rt = memwb_data;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_aluop      = aluop_q;
  assign ex_shamt      = shamt_q;
  assign ex_checkover  = checkover_q;
  assign ex_dataa      = fwd_rs;
  assign ex_datab      = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_wreg       = wreg_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
  localparam int W  = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          checkover;
    logic [4:0]    aluop;
    logic [4:0]    shamt;
    logic [RW-1:0] wreg;
    logic [W-1:0]  pc;
    logic [W-1:0]  dataa;
    logic [W-1:0]  datab;
    logic [W-1:0]  store;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          id_valid;
  logic [W-1:0]  id_pc, id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_wreg;
  logic [4:0]    id_shamt, id_aluop;
  logic          id_alusrc, id_checkover;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic          flush;
  logic          exmem_regwrite;
  logic [RW-1:0] exmem_wreg;
  logic [W-1:0]  exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_wreg;
  logic [W-1:0]  memwb_data;
  logic          lu_stall, ex_valid, ex_checkover;
  logic [W-1:0]  ex_pc, ex_dataa, ex_datab, ex_store_data;
  logic [4:0]    ex_aluop, ex_shamt;
  logic [RW-1:0] ex_wreg;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  id_ex_reg #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_wreg(id_wreg), .id_shamt(id_shamt), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_checkover(id_checkover),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_wreg(memwb_wreg), .memwb_data(memwb_data), .lu_stall(lu_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluop(ex_aluop),
    .ex_shamt(ex_shamt), .ex_checkover(ex_checkover), .ex_dataa(ex_dataa),
    .ex_datab(ex_datab), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  exp_t obs;
  assign obs = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                ex_checkover, ex_aluop, ex_shamt, ex_wreg, ex_pc,
                ex_dataa, ex_datab, ex_store_data};

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_id();
    id_valid = 0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_wreg = '0; id_shamt = '0; id_aluop = '0;
    id_alusrc = 0; id_checkover = 0; id_regwrite = 0; id_memread = 0;
    id_memwrite = 0; id_memtoreg = 0; flush = 0;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 0; exmem_wreg = '0; exmem_result = '0;
    memwb_regwrite = 0; memwb_wreg = '0; memwb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Puts a load (destination wreg) into EX and checks it arrived.
  task automatic load_lw(input logic [RW-1:0] wreg, input logic [W-1:0] pc);
    exp_t e;
    exp_t got;
    clear_id(); clear_fwd();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
    id_wreg = wreg; id_rs = 5'd2; id_rs_data = 32'h10; id_alusrc = 1;
    id_imm = 32'd4; id_pc = pc;
    e = '0; e.valid = 1; e.regwrite = 1; e.memread = 1; e.memtoreg = 1;
    e.wreg = wreg; e.pc = pc; e.dataa = 32'h10; e.datab = 32'd4;
    exp_q.push_back(e);
    step();
    clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL lw_in_ex: got %h exp %h", obs, got);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e;
    exp_t got;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1; id_pc = $urandom; id_rs_data = $urandom;
      id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 31)); id_rt = 5'($urandom_range(0, 31));
      id_wreg = 5'($urandom_range(0, 31)); id_shamt = 5'($urandom_range(0, 31));
      id_aluop = 5'($urandom_range(0, 31)); id_alusrc = 1'($urandom);
      id_checkover = 1; id_regwrite = 1; id_memread = 1; id_memwrite = 1;
      id_memtoreg = 1; flush = 1'($urandom);
      exmem_regwrite = 1; exmem_wreg = 5'($urandom_range(0, 31));
      exmem_result = $urandom; memwb_regwrite = 1;
      memwb_wreg = 5'($urandom_range(0, 31)); memwb_data = $urandom;
      exp_q.push_back('0);
      step();
      got = exp_q.pop_front();
      checks++;
      if (obs !== got) begin
        failures++;
        $display("FAIL reset_outputs: got %h exp %h", obs, got);
      end
      checks++;
      if (lu_stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_lu_stall: got %b exp 0", lu_stall);
      end
    end
    rst = 0;
    clear_id(); clear_fwd();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'd5;
    id_rt_data = 32'd7; id_regwrite = 1; id_wreg = 5'd3; id_pc = 32'h100;
    e = '0; e.valid = 1; e.regwrite = 1; e.wreg = 5'd3; e.pc = 32'h100;
    e.dataa = 32'd5; e.datab = 32'd7; e.store = 32'd7;
    exp_q.push_back(e);
    step();
    clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL first_load: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_fwd_priority();
    exp_t b;
    exp_t e;
    exp_t got;
    clear_id(); clear_fwd();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_rs_data = 32'h33;
    id_rt_data = 32'h44; id_aluop = 5'd2; id_pc = 32'h200;
    b = '0; b.valid = 1; b.aluop = 5'd2; b.pc = 32'h200;
    b.dataa = 32'h33; b.datab = 32'h44; b.store = 32'h44;
    e = b; e.dataa = 32'h11; exp_q.push_back(e);   // EX/MEM wins on rs
    e = b; e.dataa = 32'h22; exp_q.push_back(e);   // MEM/WB only on rs
    e = b; e.datab = 32'h22; e.store = 32'h22; exp_q.push_back(e);  // MEM/WB on rt
    e = b; e.datab = 32'h11; e.store = 32'h11; exp_q.push_back(e);  // EX/MEM wins on rt
    step();
    clear_id();
    exmem_regwrite = 1; exmem_wreg = 5'd3; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_wreg = 5'd3; memwb_data = 32'h22;
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL fwd_exmem_rs: got %h exp %h", obs, got);
    end
    exmem_regwrite = 0;
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL fwd_memwb_rs: got %h exp %h", obs, got);
    end
    memwb_wreg = 5'd4;
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL fwd_memwb_rt: got %h exp %h", obs, got);
    end
    exmem_regwrite = 1; exmem_wreg = 5'd4;
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL fwd_exmem_rt: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_zero_guard();
    exp_t e;
    exp_t got;
    clear_id(); clear_fwd();
    id_valid = 1; id_rs = '0; id_rt = '0; id_rs_data = 32'hAA;
    id_rt_data = 32'hBB; id_pc = 32'h300;
    e = '0; e.valid = 1; e.pc = 32'h300;
    exp_q.push_back(e);
    step();
    clear_id();
    exmem_regwrite = 1; exmem_wreg = '0; exmem_result = 32'hFF;
    memwb_regwrite = 1; memwb_wreg = '0; memwb_data = 32'hEE;
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL zero_guard: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    exp_t got;
    load_lw(5'd8, 32'h400);
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd8; id_regwrite = 1;
    id_wreg = 5'd9; id_pc = 32'h404;
    #1;
    checks++;
    if (lu_stall !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall_rt: got %b exp 1", lu_stall);
    end
    exp_q.push_back('0);
    step();
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL lu_bubble: got %h exp %h", obs, got);
    end
    checks++;
    if (lu_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_after_bubble: got %b exp 0", lu_stall);
    end
    // ID not valid: a matching specifier must not stall
    load_lw(5'd8, 32'h480);
    id_valid = 0; id_rs = 5'd8;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_id_invalid: got %b exp 0", lu_stall);
    end
    // Load targeting $0 never stalls
    load_lw(5'd0, 32'h500);
    id_valid = 1; id_rs = '0; id_rt = '0; id_regwrite = 1; id_wreg = 5'd5;
    id_pc = 32'h504;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_wreg0: got %b exp 0", lu_stall);
    end
    e = '0; e.valid = 1; e.regwrite = 1; e.wreg = 5'd5; e.pc = 32'h504;
    exp_q.push_back(e);
    step();
    clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL after_lw_wreg0: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_writethrough_imm();
    exp_t e;
    exp_t got;
    clear_id(); clear_fwd();
    id_valid = 1; id_rs = 5'd9; id_rs_data = 32'd1; id_rt = 5'd10;
    id_rt_data = 32'h77; id_alusrc = 1; id_imm = 32'hFFFF_FFF0;
    id_aluop = 5'b10000; id_checkover = 1; id_shamt = 5'd3; id_pc = 32'h600;
    id_wreg = 5'd11; id_regwrite = 1;
    memwb_regwrite = 1; memwb_wreg = 5'd9; memwb_data = 32'h40;
    e = '0; e.valid = 1; e.regwrite = 1; e.checkover = 1; e.aluop = 5'b10000;
    e.shamt = 5'd3; e.wreg = 5'd11; e.pc = 32'h600; e.dataa = 32'h40;
    e.datab = 32'hFFFF_FFF0; e.store = 32'h77;
    exp_q.push_back(e);
    step();
    clear_fwd(); clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL writethrough_rs_imm: got %h exp %h", obs, got);
    end
    id_valid = 1; id_rs = 5'd9; id_rs_data = 32'h99; id_rt = 5'd10;
    id_rt_data = 32'h1; id_pc = 32'h604;
    memwb_regwrite = 1; memwb_wreg = 5'd10; memwb_data = 32'h55;
    e = '0; e.valid = 1; e.pc = 32'h604; e.dataa = 32'h99;
    e.datab = 32'h55; e.store = 32'h55;
    exp_q.push_back(e);
    step();
    clear_fwd(); clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL writethrough_rt: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_flush_stall();
    exp_t got;
    load_lw(5'd8, 32'h700);
    id_valid = 1; id_rs = 5'd8; id_regwrite = 1; id_wreg = 5'd3;
    id_pc = 32'h704; flush = 1;
    #1;
    checks++;
    if (lu_stall !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall_with_flush: got %b exp 1", lu_stall);
    end
    exp_q.push_back('0);
    step();
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL flush_stall_bubble: got %h exp %h", obs, got);
    end
    // Flush alone with a plain instruction
    clear_id();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'h5;
    id_regwrite = 1; id_memwrite = 1; id_wreg = 5'd6; id_pc = 32'h708;
    flush = 1;
    exp_q.push_back('0);
    step();
    clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL flush_bubble: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_reset_mid();
    exp_t got;
    load_lw(5'd8, 32'h800);
    id_valid = 1; id_rt = 5'd8; id_regwrite = 1; id_wreg = 5'd4;
    id_pc = 32'h804; rst = 1;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_in_reset: got %b exp 0", lu_stall);
    end
    exp_q.push_back('0);
    step();
    rst = 0;
    clear_id();
    #1;
    got = exp_q.pop_front();
    checks++;
    if (obs !== got) begin
      failures++;
      $display("FAIL reset_mid_bubble: got %h exp %h", obs, got);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    logic pv, pmr, stall;
    logic [RW-1:0] pw;
    logic [W-1:0] rsv, rtv;
    pv = 0; pmr = 0; pw = '0;
    for (int i = 0; i < 40; i++) begin
      clear_id(); clear_fwd();
      id_valid = 1; id_pc = $urandom; id_rs_data = $urandom;
      id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_wreg = 5'($urandom_range(0, 7)); id_shamt = 5'($urandom_range(0, 31));
      id_aluop = 5'($urandom_range(0, 31)); id_alusrc = 1'($urandom);
      id_checkover = 1'($urandom); id_regwrite = 1'($urandom);
      id_memread = 1'($urandom); id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom);
      memwb_regwrite = 1'($urandom); memwb_wreg = 5'($urandom_range(0, 7));
      memwb_data = $urandom;
      stall = pv && pmr && (pw != '0) && ((pw == id_rs) || (pw == id_rt));
      #1;
      checks++;
      if (lu_stall !== stall) begin
        failures++;
        $display("FAIL rand_lu_stall[%0d]: got %b exp %b", i, lu_stall, stall);
      end
      rsv = (memwb_regwrite && memwb_wreg == id_rs) ? memwb_data : id_rs_data;
      rtv = (memwb_regwrite && memwb_wreg == id_rt) ? memwb_data : id_rt_data;
      if (id_rs == '0) rsv = '0;
      if (id_rt == '0) rtv = '0;
      e = '0;
      if (!stall) begin
        e.valid = 1; e.regwrite = id_regwrite; e.memread = id_memread;
        e.memwrite = id_memwrite; e.memtoreg = id_memtoreg;
        e.checkover = id_checkover; e.aluop = id_aluop; e.shamt = id_shamt;
        e.wreg = id_wreg; e.pc = id_pc; e.dataa = rsv;
        e.datab = id_alusrc ? id_imm : rtv; e.store = rtv;
      end
      exp_q.push_back(e);
      pv = !stall; pmr = !stall && id_memread; pw = stall ? '0 : id_wreg;
      step();
      clear_fwd();
      #1;
      got = exp_q.pop_front();
      checks++;
      if (obs !== got) begin
        failures++;
        $display("FAIL rand_ex[%0d]: got %h exp %h", i, obs, got);
      end
    end
    clear_id();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst = 1;
    clear_id();
    clear_fwd();
    test_reset();
    test_fwd_priority();
    test_zero_guard();
    test_load_use();
    test_writethrough_imm();
    test_flush_stall();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline stage that feeds the EX-stage ALU: aluop, shamt, operand A, operand B and the overflow-check enable.
- Registers decoded ID fields on each clock.
- Applies EX/MEM and MEM/WB forwarding to the registered operands.
- Selects the immediate for operand B.
- Detects load-use hazards and inserts a bubble on a load-use stall or a flush.

Parameters:
W, 32, datapath width
RW, 5, register-specifier width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  W  PC of ID instruction
id_rs_data  in  W  register-file read of rs
id_rt_data  in  W  register-file read of rt
id_imm  in  W  already-extended immediate
id_rs  in  RW  source specifier A
id_rt  in  RW  source specifier B
id_wreg  in  RW  resolved destination register
id_shamt  in  5  shift amount
id_aluop  in  5  ALU opcode
id_alusrc  in  1  1: operand B = immediate
id_checkover  in  1  enable signed overflow trap
id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  downstream controls
flush  in  1  squash ID instruction (branch/jump redirect)
exmem_regwrite  in  1  EX/MEM writes a register
exmem_wreg  in  RW  EX/MEM destination
exmem_result  in  W  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_wreg  in  RW  MEM/WB destination
memwb_data  in  W  MEM/WB writeback value
lu_stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc  out  W  registered PC
ex_aluop  out  5  to ALU aluop
ex_shamt  out  5  to ALU shamt
ex_checkover  out  1  to ALU checkover
ex_dataa  out  W  to ALU DataA, forwarded
ex_datab  out  W  to ALU DataB, forwarded or immediate
ex_store_data  out  W  forwarded rt, for sw
ex_wreg  out  RW  registered destination
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered controls

Behaviour:
- Latency: 1 cycle from ID inputs to registered EX fields. ex_dataa, ex_datab and ex_store_data are combinational from the registered fields and the forwarding inputs.
- Register update priority each edge: rst > flush > lu_stall > load.
- rst, flush and lu_stall each load a bubble. A bubble sets every registered field to 0: valid, controls, aluop (00000 = add), shamt, checkover, pc, operands, imm, specifiers.
- Reset value of every output is therefore 0, with ex_dataa = ex_datab = ex_store_data = 0.
- lu_stall = id_valid & ex_valid & ex_memread & (ex_wreg != 0) & (ex_wreg == id_rs | ex_wreg == id_rt).
  - It is asserted independently of flush.
  - It is forced to 0 while rst is high.
- Write-through on load: if memwb_regwrite and memwb_wreg == id_rs and id_rs != 0, capture memwb_data as the rs operand instead of id_rs_data. The same rule applies to rt.
- Forwarding, rs side:
  - Source is EX/MEM when exmem_regwrite & exmem_wreg != 0 & exmem_wreg == ex_rs.
  - Otherwise source is MEM/WB under the same conditions with the memwb signals.
  - Otherwise source is the registered value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded and always reads 0.
- Forwarding, rt side: same rules as rs, giving fwd_rt.
- Operand outputs:
  - ex_dataa = forwarded rs.
  - ex_datab = id_alusrc_q ? imm_q : fwd_rt.
  - ex_store_data = fwd_rt, regardless of alusrc.
- While ex_valid = 0, the forwarding muxes still operate, but all side-effect controls are 0.
- No width extension happens here; id_imm arrives already extended. lui relies on aluop 10000 with alusrc = 1.
- Simultaneous flush and lu_stall: bubble is loaded; lu_stall is still output (the upstream redirect wins).
- Reset mid-operation: the next edge clears everything, and in-flight EX state is discarded.

Test Plan:
- Reset: rst high 2 cycles with random inputs -> all outputs 0 and lu_stall 0. After release, load aluop=00000, rs_data=5, rt_data=7, alusrc=0 -> next cycle ex_dataa=5, ex_datab=7, ex_valid=1.
- EX/MEM forward priority: ex_rs=3, exmem_regwrite=1, exmem_wreg=3, exmem_result=0x11, memwb_wreg=3, memwb_data=0x22 -> ex_dataa=0x11. Drop exmem_regwrite -> ex_dataa=0x22.
- $0 guard: ex_rt=0, exmem_wreg=0, exmem_regwrite=1, exmem_result=0xFF -> ex_datab=0 and ex_store_data=0.
- Load-use: EX holds lw with ex_wreg=8; ID has id_rt=8, id_valid=1 -> lu_stall=1, and the next cycle ex_valid=0 with ex_regwrite=0. Repeat with ex_wreg=0 -> lu_stall=0.
- Write-through and immediate: id_rs=9, id_rs_data=1, memwb_regwrite=1, memwb_wreg=9, memwb_data=0x40, id_alusrc=1, id_imm=0xFFFFFFF0 -> next cycle ex_dataa=0x40, ex_datab=0xFFFFFFF0, ex_store_data=forwarded rt.
- Flush + lu_stall same cycle, and rst during a valid lw -> bubble loaded, all controls 0 next cycle.
